// File: rtl/zvn_flag_gen.sv
// +----------------------------------------------------------------------------+
// | zvn_flag_gen : digit-serial add/subtract producing result and z/v/n flags.  |
// | Optional ZVN_CARRY_OUT_EN adds the carry-out flag port c.                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module zvn_flag_gen #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             flags_valid,
  input  logic             flags_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
`ifdef ZVN_CARRY_OUT_EN
  output logic             n,
  output logic             c
`else
  output logic             n
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_zacc;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_zacc_nxt;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_accept;

  // Operand registers shift right each RUN cycle, so the active digit is always the low one.
  assign w_a_dig           = r_a[DIGIT-1:0];
  assign w_b_dig           = r_b[DIGIT-1:0];
  assign {w_cout, w_sum}   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_zacc_nxt        = r_zacc & (w_sum == '0);
  assign w_cin_msb         = w_sum[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];

  generate
    if (NDIG > 1) begin : g_multi_digit
      assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
      assign w_acc_nxt = w_sum;
    end
  endgenerate

  assign flags_valid = (r_state == S_DONE);
  assign start_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && flags_ready);
  assign w_accept    = start_valid && start_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      result  <= '0;
      z       <= 1'b0;
      v       <= 1'b0;
      n       <= 1'b0;
`ifdef ZVN_CARRY_OUT_EN
      c       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
            r_state <= S_RUN;
          end else if ((r_state == S_DONE) && flags_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_nxt;
          r_carry <= w_cout;
          r_zacc  <= w_zacc_nxt;
          if (r_cnt == C_LAST) begin
            result  <= w_acc_nxt;
            z       <= w_zacc_nxt;
            n       <= w_sum[DIGIT-1];
            v       <= w_cin_msb ^ w_cout;
`ifdef ZVN_CARRY_OUT_EN
            c       <= w_cout;
`endif
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zvn_flag_gen.sv
// +----------------------------------------------------------------------------+
// | tb_zvn_flag_gen : directed and random checks of zvn_flag_gen.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_zvn_flag_gen;

  localparam int W    = 32;
  localparam int D    = 8;
  localparam int NDIG = W / D;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         v;
    logic         n;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         flags_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         start_ready;
  logic         flags_valid;
  logic [W-1:0] result;
  logic         z;
  logic         v;
  logic         n;
`ifdef ZVN_CARRY_OUT_EN
  logic         c;
`endif

  int n_vec = 0;
  int n_bad = 0;

  zvn_flag_gen #(.WIDTH(W), .DIGIT(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .a           (a),
    .b           (b),
    .flags_valid (flags_valid),
    .flags_ready (flags_ready),
    .result      (result),
    .z           (z),
    .v           (v),
`ifdef ZVN_CARRY_OUT_EN
    .n           (n),
    .c           (c)
`else
    .n           (n)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference arithmetic from the operand values directly.
  function automatic exp_t model(input logic sub, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t   e;
    longint sa, sb, sr;
    logic [W:0] wide;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    if (sub) begin
      e.r = aa - bb;
      e.c = (aa >= bb);
      sr  = sa - sb;
    end else begin
      wide = {1'b0, aa} + {1'b0, bb};
      e.r  = wide[W-1:0];
      e.c  = wide[W];
      sr   = sa + sb;
    end
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    e.v = (sr > longint'(32'sh7FFFFFFF)) || (sr < -longint'(64'h80000000));
    return e;
  endfunction

  logic m_valid = 1'b0;
  int   m_cnt   = 0;
  exp_t m_out   = '0;
  exp_t m_pend  = '0;

  always @(negedge clk) begin
    logic exp_sr;
    if (!reset_n) begin
      chk("rst_start_ready", start_ready, 1);
      chk("rst_flags_valid", flags_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zvn", {z, v, n}, 0);
`ifdef ZVN_CARRY_OUT_EN
      chk("rst_c", c, 0);
`endif
      m_valid = 1'b0;
      m_cnt   = 0;
      m_out   = '0;
    end else begin
      exp_sr = ((m_cnt == 0) && !m_valid) || (m_valid && flags_ready);
      chk("flags_valid", flags_valid, m_valid);
      chk("start_ready", start_ready, exp_sr);
      chk("result", result, m_out.r);
      chk("z", z, m_out.z);
      chk("v", v, m_out.v);
      chk("n", n, m_out.n);
`ifdef ZVN_CARRY_OUT_EN
      chk("c", c, m_out.c);
`endif
      if (m_valid && flags_ready) m_valid = 1'b0;
      if (start_valid && exp_sr) begin
        m_cnt  = NDIG;
        m_pend = model(op_sub, a, b);
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_out   = m_pend;
        end
      end
    end
  end

  task automatic issue(input logic sub, input logic [W-1:0] aa, input logic [W-1:0] bb);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b1; op_sub = sub; a = aa; b = bb;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = start_ready;
      @(posedge clk); #1;
    end
    start_valid = 1'b0; a = $urandom; b = $urandom; op_sub = 1'($urandom);
    if (!ok) chk("issue_timeout", 0, 1);
  endtask

  task automatic wait_flags(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (flags_valid) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    if (!ok) chk("flags_timeout", 0, 1);
  endtask

  task automatic check_lit(input string nm, input logic [W-1:0] r, input logic ez, ev, en, ec);
    chk({nm, "_result"}, result, r);
    chk({nm, "_zvn"}, {z, v, n}, {ez, ev, en});
`ifdef ZVN_CARRY_OUT_EN
    chk({nm, "_c"}, c, ec);
`else
    if (ec === 1'bx) chk({nm, "_c"}, 0, 1);
`endif
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 5)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; flags_ready = 1'b1;

    issue(1'b1, 32'd5, 32'd5);
    wait_flags(lat);
    chk("lat_5m5", lat, NDIG);
    check_lit("sub5_5", 32'h0, 1, 0, 0, 1);

    issue(1'b1, 32'd3, 32'd5);
    wait_flags(lat);
    check_lit("sub3_5", 32'hFFFFFFFE, 0, 0, 1, 0);

    issue(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF);
    wait_flags(lat);
    check_lit("sub_ovf", 32'h80000000, 0, 1, 1, 0);

    issue(1'b0, 32'h80000000, 32'h80000000);
    wait_flags(lat);
    check_lit("add_ovf", 32'h0, 1, 1, 0, 1);

    issue(1'b0, 32'h000000FF, 32'h1);
    wait_flags(lat);
    check_lit("carry_dig", 32'h00000100, 0, 0, 0, 0);

    issue(1'b0, 32'hFFFFFFFF, 32'h1);
    wait_flags(lat);
    check_lit("carry_all", 32'h0, 1, 0, 0, 1);

    // Backpressure, then same-edge consume and accept.
    @(posedge clk); #1 flags_ready = 1'b0;
    issue(1'b0, 32'h12345678, 32'h11111111);
    wait_flags(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result", result, 32'h23456789);
      chk("bp_start_ready", start_ready, 0);
      chk("bp_flags_valid", flags_valid, 1);
    end
    @(posedge clk); #1 flags_ready = 1'b1;
    issue(1'b0, 32'd1, 32'd1);
    wait_flags(lat);
    chk("lat_b2b", lat, NDIG);
    check_lit("b2b", 32'd2, 0, 0, 0, 0);

    // Reset in the middle of RUN.
    issue(1'b0, 32'h00001234, 32'h00004321);
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_valid", flags_valid, 0);
    chk("mid_rst_flags", {result, z, v, n}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", flags_valid, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start_valid = ($urandom % 2) == 0;
      op_sub      = 1'($urandom);
      a           = pick();
      b           = pick();
      flags_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1 start_valid = 1'b0; flags_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
